run_pattern_tx: RTL and testbench

Serial run-pattern transmitter: the stimulus-side counterpart of the run detector. It accepts run requests (bit value, run length) over a valid/ready handshake. Each request is serialized onto a single-bit stream `x` as a run of identical bits, optionally followed by a one-cycle complementary separator bit. It drives run-detector inputs in block-level benches and on-chip self-test paths.

---
 rtl/run_pattern_tx_if.sv | 24 ++
 rtl/run_pattern_tx.sv | 95 +++++++++
 tb/tb_run_pattern_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/run_pattern_tx_if.sv
// Run request handshake bundle for run_pattern_tx.
// Carries valid/ready plus the run bit and run length.
interface run_pattern_tx_if #(
    parameter int LEN_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_bit;
    logic [LEN_W-1:0] req_len;

    modport master (
        output req_valid,
        output req_bit,
        output req_len,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_bit,
        input  req_len,
        output req_ready
    );
endinterface

// File: rtl/run_pattern_tx.sv
// Serial run-pattern transmitter: turns (bit, length) requests into runs
// of identical bits on x, with an optional complementary separator bit.
// Ports: clk, reset (sync, active-high), req (slave handshake: valid,
// ready, bit, len), hold (stall), x/x_valid (serial stream), run_done
// (pulse on last bit of a run), run_count (completed runs, wraps), busy.
module run_pattern_tx #(
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 8,
    parameter int INSERT_SEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    run_pattern_tx_if.slave   req,
    input  logic              hold,
    output logic              x,
    output logic              x_valid,
    output logic              run_done,
    output logic [CNT_W-1:0]  run_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        SEP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               bit_q, bit_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        count_d   = count_q;
        x         = 1'b0;
        x_valid   = 1'b0;
        run_done  = 1'b0;
        req.req_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                req.req_ready = 1'b1;
                // A zero-length request completes the handshake only.
                if (req.req_valid && (req.req_len != '0)) begin
                    bit_d   = req.req_bit;
                    cnt_d   = req.req_len;
                    state_d = SEND;
                end
            end
            SEND: begin
                x       = bit_q;
                x_valid = ~hold;
                if (!hold) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        run_done = 1'b1;
                        count_d  = count_q + 1'b1;
                        state_d  = (INSERT_SEP != 0) ? SEP : IDLE;
                    end
                end
            end
            SEP: begin
                x       = ~bit_q;
                x_valid = ~hold;
                if (!hold) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign run_count = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_run_pattern_tx.sv
// Directed self-checking bench for run_pattern_tx.
// Hand-computed per-cycle expectations plus a loopback run detector.
module tb_run_pattern_tx;

    localparam int LEN_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             hold = 1'b0;
    logic             x, x_valid, run_done, busy;
    logic [CNT_W-1:0] run_count;

    int total = 0;
    int bad   = 0;

    run_pattern_tx_if #(.LEN_W(LEN_W)) req ();

    run_pattern_tx #(
        .LEN_W(LEN_W),
        .CNT_W(CNT_W),
        .INSERT_SEP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req.slave),
        .hold(hold),
        .x(x),
        .x_valid(x_valid),
        .run_done(run_done),
        .run_count(run_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Loopback run detector, threshold 3; an invalid cycle ends a run.
    logic det_clr = 1'b1;
    logic det_prev;
    int   det_len;
    int   det_hits;

    always @(posedge clk) begin
        if (det_clr) begin
            det_len  <= 0;
            det_prev <= 1'b0;
            det_hits <= 0;
        end else if (x_valid) begin
            if (det_len != 0 && x == det_prev) begin
                det_len <= det_len + 1;
            end else begin
                if (det_len >= 3) det_hits <= det_hits + 1;
                det_len <= 1;
            end
            det_prev <= x;
        end else begin
            if (det_len >= 3) det_hits <= det_hits + 1;
            det_len <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ob(input string tag, input logic ex, input logic ev,
                      input logic ed, input logic eb);
        chk({tag, ".x"}, {31'd0, x}, {31'd0, ex});
        chk({tag, ".xv"}, {31'd0, x_valid}, {31'd0, ev});
        chk({tag, ".done"}, {31'd0, run_done}, {31'd0, ed});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        #1;
    endtask

    task automatic rst();
        reset = 1'b1;
        req.req_valid = 1'b0;
        hold = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        req.req_valid = 1'b0;
        req.req_bit   = 1'b0;
        req.req_len   = '0;
        rst();

        // Reset state
        ob("rst", 0, 0, 0, 0);
        chk("rst.ready", {31'd0, req.req_ready}, 1);
        chk("rst.count", {24'd0, run_count}, 0);

        // Single run (1,3) with separator
        req.req_valid = 1'b1;
        req.req_bit   = 1'b1;
        req.req_len   = 4'd3;
        #1;
        chk("t1.ready", {31'd0, req.req_ready}, 1);
        nxt();
        req.req_valid = 1'b0;
        ob("t1c2", 1, 1, 0, 1);
        chk("t1c2.ready", {31'd0, req.req_ready}, 0);
        nxt(); ob("t1c3", 1, 1, 0, 1);
        nxt(); ob("t1c4", 1, 1, 1, 1);
        nxt(); ob("t1c5", 0, 1, 0, 1);
        nxt(); ob("t1c6", 0, 0, 0, 0);
        chk("t1c6.ready", {31'd0, req.req_ready}, 1);
        chk("t1c6.count", {24'd0, run_count}, 1);

        // Back-to-back (0,2) then (1,3)
        rst();
        req.req_valid = 1'b1;
        req.req_bit   = 1'b0;
        req.req_len   = 4'd2;
        nxt();
        req.req_bit = 1'b1;
        req.req_len = 4'd3;
        ob("b2b0", 0, 1, 0, 1);
        nxt(); ob("b2b1", 0, 1, 1, 1);
        nxt(); ob("b2b2", 1, 1, 0, 1);
        nxt(); ob("b2b3", 0, 0, 0, 0);
        nxt();
        req.req_valid = 1'b0;
        ob("b2b4", 1, 1, 0, 1);
        nxt(); ob("b2b5", 1, 1, 0, 1);
        nxt(); ob("b2b6", 1, 1, 1, 1);
        nxt(); ob("b2b7", 0, 1, 0, 1);
        nxt(); ob("b2b8", 0, 0, 0, 0);
        chk("b2b.count", {24'd0, run_count}, 2);

        // Zero-length request
        rst();
        req.req_valid = 1'b1;
        req.req_bit   = 1'b1;
        req.req_len   = 4'd0;
        #1;
        chk("z.ready", {31'd0, req.req_ready}, 1);
        nxt();
        req.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ob("z", 0, 0, 0, 0);
            chk("z.count", {24'd0, run_count}, 0);
            nxt();
        end

        // Hold during SEND cycles 2,3 and in SEP
        rst();
        req.req_valid = 1'b1;
        req.req_bit   = 1'b1;
        req.req_len   = 4'd4;
        nxt();
        req.req_valid = 1'b0;
        ob("h1", 1, 1, 0, 1);
        nxt(); hold = 1'b1; #1; ob("h2", 1, 0, 0, 1);
        nxt(); ob("h3", 1, 0, 0, 1);
        nxt(); hold = 1'b0; #1; ob("h4", 1, 1, 0, 1);
        nxt(); ob("h5", 1, 1, 0, 1);
        nxt(); ob("h6", 1, 1, 1, 1);
        nxt(); hold = 1'b1; #1; ob("hsep_hold", 0, 0, 0, 1);
        nxt(); hold = 1'b0; #1; ob("hsep", 0, 1, 0, 1);
        nxt(); ob("hidle", 0, 0, 0, 0);
        chk("h.count", {24'd0, run_count}, 1);

        // Max length, reset after 6 valid bits
        rst();
        req.req_valid = 1'b1;
        req.req_bit   = 1'b1;
        req.req_len   = 4'd15;
        nxt();
        req.req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ob("max", 1, 1, 0, 1);
            nxt();
        end
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        #1;
        ob("abort", 0, 0, 0, 0);
        chk("abort.count", {24'd0, run_count}, 0);
        chk("abort.ready", {31'd0, req.req_ready}, 1);
        req.req_valid = 1'b1;
        req.req_bit   = 1'b1;
        req.req_len   = 4'd2;
        nxt();
        req.req_valid = 1'b0;
        ob("ab1", 1, 1, 0, 1);
        nxt(); ob("ab2", 1, 1, 1, 1);
        nxt(); ob("ab3", 0, 1, 0, 1);
        nxt(); ob("ab4", 0, 0, 0, 0);
        chk("ab.count", {24'd0, run_count}, 1);

        // 256 runs of (1,1): counter wraps
        rst();
        req.req_valid = 1'b1;
        req.req_bit   = 1'b1;
        req.req_len   = 4'd1;
        #1;
        for (int i = 1; i <= 256; i++) begin
            int k;
            logic [7:0] e;
            k = 0;
            while (!run_done && k < 6) begin
                nxt();
                k++;
            end
            chk("wrap.done", {31'd0, run_done}, 1);
            nxt();
            e = i[7:0];
            chk("wrap.count", {24'd0, run_count}, {24'd0, e});
        end
        req.req_valid = 1'b0;

        // Loopback: runs 2,3,5; detector threshold 3 sees two
        rst();
        nxt();
        det_clr = 1'b0;
        req.req_valid = 1'b1;
        req.req_bit = 1'b1; req.req_len = 4'd2;
        nxt();
        req.req_bit = 1'b0; req.req_len = 4'd3;
        nxt(); nxt(); nxt();
        chk("lb.rdy2", {31'd0, req.req_ready}, 1);
        nxt();
        req.req_bit = 1'b1; req.req_len = 4'd5;
        nxt(); nxt(); nxt(); nxt();
        chk("lb.rdy3", {31'd0, req.req_ready}, 1);
        nxt();
        req.req_valid = 1'b0;
        for (int i = 0; i < 9; i++) nxt();
        chk("lb.hits", det_hits, 2);
        chk("lb.count", {24'd0, run_count}, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
